output_packer: RTL

//  Downstream neighbour of the output scaler: accepts one vector of numElements saturated
//  int8 activations per beat (valid/ready) and packs beatsPerWord beats into one wordWidth

---
 rtl/accelerator_package.sv | 19 +
 rtl/output_packer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/accelerator_package.sv
// Shared types for the output packer: job configuration and FSM state.
package accelerator_package;

   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned COUNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      PACK,
      DRAIN,
      DONE
   } opacker_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0]  base_addr;
      logic [COUNT_W-1:0] num_beats;
   } cfg_opacker_t;

endpackage

// File: rtl/output_packer.sv
// Packs saturated activation beats into write-port words with incrementing addresses,
// zero-padding and byte-strobing a partial final word, and pulses done_o at job end.
module output_packer
   import accelerator_package::*;
#(
   parameter int unsigned numElements = 4,
   parameter int unsigned outputWidth = 8,
   parameter int unsigned wordWidth   = 64,
   parameter int unsigned addrWidth   = ADDR_W,
   parameter int unsigned countWidth  = COUNT_W
) (
   input  logic                               clk,
   input  logic                               nrst,
   input  logic                               start_i,
   input  cfg_opacker_t                       cfg_i,
   input  logic [numElements*outputWidth-1:0] y_i,
   input  logic                               y_valid_i,
   output logic                               y_ready_o,
   output logic                               wr_valid_o,
   input  logic                               wr_ready_i,
   output logic [addrWidth-1:0]               wr_addr_o,
   output logic [wordWidth-1:0]               wr_data_o,
   output logic [wordWidth/8-1:0]             wr_strb_o,
   output logic                               busy_o,
   output logic                               done_o
);

   localparam int unsigned beatWidth    = numElements * outputWidth;
   localparam int unsigned beatsPerWord = wordWidth / beatWidth;
   localparam int unsigned strbWidth    = wordWidth / 8;
   localparam int unsigned beatBytes    = beatWidth / 8;
   localparam int unsigned slotWidth    = (beatsPerWord > 1) ? $clog2(beatsPerWord) : 1;

   if ((wordWidth % beatWidth) != 0 || (outputWidth % 8) != 0 ||
       addrWidth != ADDR_W || countWidth != COUNT_W) begin : g_bad_cfg
      $fatal(1, "output_packer: illegal parameter combination");
   end

   opacker_state_t state, state_nxt;

   logic [countWidth-1:0] beats_left;
   logic [slotWidth-1:0]  slot;
   logic [wordWidth-1:0]  pack_data;
   logic [strbWidth-1:0]  pack_strb;
   logic [addrWidth-1:0]  next_addr;
   logic [wordWidth-1:0]  merged_data;
   logic [strbWidth-1:0]  merged_strb;
   logic                  last_beat;
   logic                  word_done;
   logic                  beat_fire;
   logic                  wr_fire;

   // Handshake terms and the word as it would look with the current beat inserted.
   always_comb begin
      last_beat   = (beats_left == countWidth'(1));
      word_done   = (slot == slotWidth'(beatsPerWord - 1)) || last_beat;
      y_ready_o   = (state == PACK) && !(word_done && wr_valid_o && !wr_ready_i);
      beat_fire   = y_valid_i && y_ready_o;
      wr_fire     = wr_valid_o && wr_ready_i;
      merged_data = pack_data;
      merged_strb = pack_strb;
      for (int unsigned k = 0; k < beatsPerWord; k++) begin
         if (slot == slotWidth'(k)) begin
            merged_data[k*beatWidth +: beatWidth] = y_i;
            merged_strb[k*beatBytes +: beatBytes] = '1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (state)
         IDLE: begin
            if (start_i) begin
               state_nxt = (cfg_i.num_beats == '0) ? DONE : PACK;
            end
         end
         PACK: begin
            busy_o = 1'b1;
            if (beat_fire && last_beat) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            busy_o = 1'b1;
            if (wr_fire) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pack register, counters and the output word register share one reset domain.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         beats_left <= '0;
         slot       <= '0;
         pack_data  <= '0;
         pack_strb  <= '0;
         next_addr  <= '0;
         wr_valid_o <= 1'b0;
         wr_addr_o  <= '0;
         wr_data_o  <= '0;
         wr_strb_o  <= '0;
      end else begin
         if (state == IDLE && start_i) begin
            next_addr  <= cfg_i.base_addr;
            beats_left <= cfg_i.num_beats;
            slot       <= '0;
            pack_data  <= '0;
            pack_strb  <= '0;
         end

         if (beat_fire) begin
            beats_left <= beats_left - countWidth'(1);
            if (word_done) begin
               slot      <= '0;
               pack_data <= '0;
               pack_strb <= '0;
            end else begin
               slot      <= slot + slotWidth'(1);
               pack_data <= merged_data;
               pack_strb <= merged_strb;
            end
         end

         if (beat_fire && word_done) begin
            wr_valid_o <= 1'b1;
            wr_addr_o  <= next_addr;
            wr_data_o  <= merged_data;
            wr_strb_o  <= merged_strb;
            next_addr  <= next_addr + addrWidth'(1);
         end else if (wr_fire) begin
            wr_valid_o <= 1'b0;
         end
      end
   end

endmodule
